// File: rtl/uart_rx_framer.sv
// uart_rx_framer: turns a stream of received UART bytes into
// length-prefixed frames (SOF, LEN, payload, CHK). Payload bytes are
// streamed out with first/last markers, and each frame closes with a
// one-cycle good/error verdict.
module uart_rx_framer #(
  parameter logic [7:0] SOF_BYTE     = 8'hA5,
  parameter int         MAX_LEN      = 64,
  parameter int         TIMEOUT_CLKS = 2500
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_recv,
  output logic [7:0] pl_data,
  output logic       pl_valid,
  output logic       pl_first,
  output logic       pl_last,
  output logic [7:0] frm_len,
  output logic       frm_ok,
  output logic       frm_err,
  output logic [1:0] err_code,
  output logic       busy
);

  localparam int CW = $clog2(MAX_LEN + 1);
  localparam int GW = $clog2(TIMEOUT_CLKS);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GET_LEN = 2'd1,
    S_PAYLOAD = 2'd2,
    S_GET_CHK = 2'd3
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [GW-1:0]   r_gap;
  logic [7:0]      r_sum;
  logic [7:0]      r_pl_data;
  logic            r_pl_valid;
  logic            r_pl_first;
  logic            r_pl_last;
  logic [7:0]      r_frm_len;
  logic            r_frm_ok;
  logic            r_frm_err;
  logic [1:0]      r_err_code;

  logic            w_expire;
  logic            w_is_last;
  logic            w_bad_len;

  // Gap limit reached with no byte this cycle; a byte arriving now wins.
  assign w_expire  = !rx_recv && (r_gap == GW'(TIMEOUT_CLKS - 1));
  // Current payload byte is the LEN-th one (LEN is at least 1 here).
  assign w_is_last = (8'(r_cnt) == (r_frm_len - 8'd1));
  assign w_bad_len = (rx_data == 8'd0) || (rx_data > 8'(MAX_LEN));

  // Frame parser: state, counters, checksum and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_gap      <= '0;
      r_sum      <= '0;
      r_pl_data  <= '0;
      r_pl_valid <= 1'b0;
      r_pl_first <= 1'b0;
      r_pl_last  <= 1'b0;
      r_frm_len  <= '0;
      r_frm_ok   <= 1'b0;
      r_frm_err  <= 1'b0;
      r_err_code <= '0;
    end else begin
      r_pl_valid <= 1'b0;
      r_pl_first <= 1'b0;
      r_pl_last  <= 1'b0;
      r_frm_ok   <= 1'b0;
      r_frm_err  <= 1'b0;

      // Gap counter only runs inside a frame; every byte restarts it.
      if (rx_recv) begin
        r_gap <= '0;
      end else if (r_state != S_IDLE) begin
        r_gap <= r_gap + GW'(1);
      end

      case (r_state)
        S_IDLE: begin
          r_gap <= '0;
          if (rx_recv && (rx_data == SOF_BYTE)) begin
            r_state <= S_GET_LEN;
          end
        end

        S_GET_LEN: begin
          if (rx_recv) begin
            r_frm_len <= rx_data;
            r_sum     <= rx_data;
            r_cnt     <= '0;
            if (w_bad_len) begin
              r_frm_err  <= 1'b1;
              r_err_code <= 2'b01;
              r_state    <= S_IDLE;
            end else begin
              r_state <= S_PAYLOAD;
            end
          end else if (w_expire) begin
            r_frm_err  <= 1'b1;
            r_err_code <= 2'b11;
            r_gap      <= '0;
            r_state    <= S_IDLE;
          end
        end

        S_PAYLOAD: begin
          // SOF_BYTE inside the payload is ordinary data.
          if (rx_recv) begin
            r_pl_data  <= rx_data;
            r_pl_valid <= 1'b1;
            r_pl_first <= (r_cnt == '0);
            r_pl_last  <= w_is_last;
            r_sum      <= r_sum + rx_data;
            r_cnt      <= r_cnt + CW'(1);
            if (w_is_last) begin
              r_state <= S_GET_CHK;
            end
          end else if (w_expire) begin
            r_frm_err  <= 1'b1;
            r_err_code <= 2'b11;
            r_gap      <= '0;
            r_state    <= S_IDLE;
          end
        end

        S_GET_CHK: begin
          if (rx_recv) begin
            if (rx_data == r_sum) begin
              r_frm_ok <= 1'b1;
            end else begin
              r_frm_err  <= 1'b1;
              r_err_code <= 2'b10;
            end
            r_state <= S_IDLE;
          end else if (w_expire) begin
            r_frm_err  <= 1'b1;
            r_err_code <= 2'b11;
            r_gap      <= '0;
            r_state    <= S_IDLE;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign pl_data  = r_pl_data;
  assign pl_valid = r_pl_valid;
  assign pl_first = r_pl_first;
  assign pl_last  = r_pl_last;
  assign frm_len  = r_frm_len;
  assign frm_ok   = r_frm_ok;
  assign frm_err  = r_frm_err;
  assign err_code = r_err_code;
  // busy drops on the same edge that registers the verdict pulse.
  assign busy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_framer.sv
// Bench for uart_rx_framer: a frame-level reference model checked against
// the DUT every cycle, plus directed frames with literal expectations.
module tb_uart_rx_framer;

  localparam logic [7:0] SOF     = 8'hA5;
  localparam int         MAXL    = 64;
  localparam int         TOUT    = 2500;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_recv = 1'b0;
  logic [7:0] pl_data;
  logic       pl_valid, pl_first, pl_last;
  logic [7:0] frm_len;
  logic       frm_ok, frm_err;
  logic [1:0] err_code;
  logic       busy;

  uart_rx_framer #(.SOF_BYTE(SOF), .MAX_LEN(MAXL), .TIMEOUT_CLKS(TOUT)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_recv(rx_recv),
    .pl_data(pl_data), .pl_valid(pl_valid), .pl_first(pl_first),
    .pl_last(pl_last), .frm_len(frm_len), .frm_ok(frm_ok),
    .frm_err(frm_err), .err_code(err_code), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: frame position (-1 outside a frame, 0 awaiting LEN, then
  // payload bytes collected in a queue, then CHK) and the edge index of
  // the last sampled byte, from which the timeout is computed directly.
  int         cyc    = 0;
  int         m_last = 0;
  int         pos    = -1;
  int         mlen   = 0;
  int         msum;
  logic [7:0] q[$];
  logic [7:0] e_data = 0, e_len = 0;
  logic       e_valid = 0, e_first = 0, e_last = 0, e_ok = 0, e_err = 0, e_busy = 0;
  logic [1:0] e_code = 0;

  // Observations of the DUT for the directed checks (edge indices).
  logic [7:0] pl_log[$];
  logic [1:0] fl_log[$];
  int ok_cnt = 0, err_cnt = 0, ok_edge = 0, err_edge = 0;
  logic [1:0] err_seen = 0;

  // Reference model step and per-cycle compare.
  initial begin
    logic s_rst, s_recv;
    logic [7:0] s_data;
    logic bad;
    forever begin
      @(posedge clk);
      s_rst = rst; s_recv = rx_recv; s_data = rx_data;
      cyc++;
      if (s_rst) begin
        pos = -1; q.delete();
        e_data = 0; e_len = 0; e_valid = 0; e_first = 0; e_last = 0;
        e_ok = 0; e_err = 0; e_code = 0; e_busy = 0;
      end else begin
        e_valid = 0; e_first = 0; e_last = 0; e_ok = 0; e_err = 0;
        if (s_recv) begin
          m_last = cyc;
          if (pos < 0) begin
            if (s_data == SOF) pos = 0;
          end else if (pos == 0) begin
            e_len = s_data; mlen = int'(s_data); q.delete();
            if (mlen == 0 || mlen > MAXL) begin
              e_err = 1; e_code = 2'b01; pos = -1;
            end else pos = 1;
          end else if (q.size() < mlen) begin
            e_data = s_data; e_valid = 1;
            e_first = (q.size() == 0);
            q.push_back(s_data);
            e_last = (q.size() == mlen);
            pos++;
          end else begin
            msum = mlen;
            foreach (q[i]) msum += int'(q[i]);
            if (int'(s_data) == (msum % 256)) e_ok = 1;
            else begin e_err = 1; e_code = 2'b10; end
            pos = -1;
          end
        end else if (pos >= 0 && (cyc - m_last) == TOUT) begin
          e_err = 1; e_code = 2'b11; pos = -1;
        end
        e_busy = (pos >= 0);
      end
      #1;
      bad = (pl_valid !== e_valid) || (pl_data !== e_data) ||
            (e_valid && ((pl_first !== e_first) || (pl_last !== e_last))) ||
            (frm_len !== e_len) || (frm_ok !== e_ok) || (frm_err !== e_err) ||
            (err_code !== e_code) || (busy !== e_busy);
      n_checks++;
      if (bad) begin
        n_fail++;
        $display("FAIL cycle %0d model: act v=%b d=%h f=%b l=%b len=%h ok=%b err=%b code=%0d busy=%b exp v=%b d=%h f=%b l=%b len=%h ok=%b err=%b code=%0d busy=%b",
                 cyc, pl_valid, pl_data, pl_first, pl_last, frm_len, frm_ok, frm_err, err_code, busy,
                 e_valid, e_data, e_first, e_last, e_len, e_ok, e_err, e_code, e_busy);
      end
      if (pl_valid) begin pl_log.push_back(pl_data); fl_log.push_back({pl_first, pl_last}); end
      if (frm_ok) begin ok_cnt++; ok_edge = cyc; end
      if (frm_err) begin err_cnt++; err_edge = cyc; err_seen = err_code; end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Called at a falling edge; the byte is sampled on the next rising edge.
  task automatic send(input logic [7:0] b);
    rx_data = b; rx_recv = 1'b1;
    @(negedge clk);
    rx_recv = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  int ok0, err0, s;
  logic [7:0] c;

  initial begin
    idle(3);
    check("rst_busy", int'(busy), 0);
    check("rst_pl_valid", int'(pl_valid), 0);
    check("rst_frm_len", int'(frm_len), 0);
    check("rst_err_code", int'(err_code), 0);
    rst = 1'b0;
    idle(2);

    // 1: good frame
    pl_log.delete(); fl_log.delete(); ok0 = ok_cnt; err0 = err_cnt;
    send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h69);
    s = m_last;
    idle(3);
    check("t1_pl_count", pl_log.size(), 3);
    if (pl_log.size() == 3) begin
      check("t1_pl0", int'(pl_log[0]), 'h11);
      check("t1_pl1", int'(pl_log[1]), 'h22);
      check("t1_pl2", int'(pl_log[2]), 'h33);
      check("t1_flags0", int'(fl_log[0]), 2'b10);
      check("t1_flags2", int'(fl_log[2]), 2'b01);
    end
    check("t1_ok", ok_cnt - ok0, 1);
    check("t1_err", err_cnt - err0, 0);
    // Verdict is registered by the edge that samples CHK (visible next cycle).
    check("t1_ok_edge", ok_edge - s, 0);
    check("t1_frm_len", int'(frm_len), 3);

    // 2: bad checksum
    pl_log.delete(); ok0 = ok_cnt; err0 = err_cnt;
    send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h68);
    idle(3);
    check("t2_pl_count", pl_log.size(), 3);
    check("t2_err", err_cnt - err0, 1);
    check("t2_code", int'(err_seen), 2);
    check("t2_ok", ok_cnt - ok0, 0);

    // 3: length limits
    pl_log.delete(); err0 = err_cnt;
    send(8'hA5); send(8'h00); idle(3);
    check("t3_len0_err", err_cnt - err0, 1);
    check("t3_len0_code", int'(err_seen), 1);
    check("t3_len0_pl", pl_log.size(), 0);
    err0 = err_cnt;
    send(8'hA5); send(8'h41); idle(3);
    check("t3_len65_err", err_cnt - err0, 1);
    check("t3_len65_code", int'(err_seen), 1);
    pl_log.delete(); ok0 = ok_cnt;
    send(8'hA5); send(8'h40);
    for (int i = 1; i <= 64; i++) send(8'(i));
    c = 8'h60;                        // 0x40 + (1+..+64) = 2144 = 0x860
    send(c); idle(3);
    check("t3_len64_ok", ok_cnt - ok0, 1);
    check("t3_len64_pl", pl_log.size(), 64);
    check("t3_len64_frm_len", int'(frm_len), 64);

    // 4: garbage, single-byte frame, SOF as payload right after CHK
    send(8'h00); check("t4_busy_00", int'(busy), 0);
    send(8'hFF); check("t4_busy_ff", int'(busy), 0);
    send(8'h5A); check("t4_busy_5a", int'(busy), 0);
    pl_log.delete(); fl_log.delete(); ok0 = ok_cnt;
    send(8'hA5); check("t4_busy_a5", int'(busy), 1);
    send(8'h01); send(8'h7E); send(8'h7F);
    send(8'hA5); send(8'h02); send(8'hA5); send(8'hA5); send(8'h4C);
    idle(3);
    check("t4_pl_count", pl_log.size(), 3);
    if (pl_log.size() == 3) begin
      check("t4_single_data", int'(pl_log[0]), 'h7E);
      check("t4_single_flags", int'(fl_log[0]), 2'b11);
      check("t4_sof_pl1", int'(pl_log[1]), 'hA5);
      check("t4_sof_pl2", int'(pl_log[2]), 'hA5);
    end
    check("t4_ok", ok_cnt - ok0, 2);

    // 5a: timeout after the last payload byte
    err0 = err_cnt;
    send(8'hA5); send(8'h02); send(8'h44);
    s = m_last;
    idle(2600);
    check("t5_err", err_cnt - err0, 1);
    check("t5_code", int'(err_seen), 3);
    check("t5_edge", err_edge - s, TOUT);
    check("t5_busy", int'(busy), 0);

    // 5b: byte sampled on the expiry edge keeps the frame alive
    err0 = err_cnt; ok0 = ok_cnt;
    send(8'hA5); send(8'h02); send(8'h44);
    idle(TOUT - 1);
    send(8'h55);
    idle(50);
    check("t5b_no_err", err_cnt - err0, 0);
    check("t5b_busy", int'(busy), 1);
    send(8'h9B); idle(3);
    check("t5b_ok", ok_cnt - ok0, 1);

    // 6: reset mid-frame
    err0 = err_cnt; ok0 = ok_cnt;
    send(8'hA5); send(8'h03); send(8'h11);
    check("t6_pre_busy", int'(busy), 1);
    check("t6_pre_data", int'(pl_data), 'h11);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_busy", int'(busy), 0);
    check("t6_rst_data", int'(pl_data), 0);
    check("t6_rst_len", int'(frm_len), 0);
    check("t6_rst_code", int'(err_code), 0);
    idle(2);
    rst = 1'b0;
    idle(2);
    send(8'hA5); send(8'h01); send(8'h7E); send(8'h7F); idle(3);
    check("t6_no_err", err_cnt - err0, 0);
    check("t6_ok", ok_cnt - ok0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
